// File: rtl/nexys_starship_pkg.sv
// Shared definitions for the starship monster controller.
//   - Lane index constants (bit positions in the 4-bit lane vectors).
//   - Lane FSM state encoding.
//   - popcount4 helper for aggregating per-lane pulses.
package nexys_starship_pkg;

    localparam int NUM_LANES  = 4;
    localparam int LANE_TOP   = 0;
    localparam int LANE_BTM   = 1;
    localparam int LANE_LEFT  = 2;
    localparam int LANE_RIGHT = 3;

    typedef enum logic [1:0] {
        LANE_IDLE   = 2'd0,
        LANE_ACTIVE = 2'd1,
        LANE_COOL   = 2'd2
    } lane_state_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/nexys_starship_lane.sv
// One monster lane: spawn, lifetime countdown, shot kill, post-kill cooldown.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no monster; accepts a spawn request
// ACTIVE | monster alive; timer counts remaining lifetime ticks
// COOL   | monster just killed; timer counts cooldown before respawn
//
// Ports:
//   Clk, Reset      clock, async active-high reset
//   Tick            game-time enable; timers only move on Tick
//   abort           forces IDLE on the next edge with no pulses
//   spawn           spawn request for this lane
//   shot            shot at this lane
//   life_load       value loaded into the timer at spawn (lifetime - 1)
//   monster_active  lane is in ACTIVE
//   kill_pulse      one-cycle pulse on a kill
//   escape_pulse    one-cycle pulse when the lifetime runs out
module nexys_starship_lane
    import nexys_starship_pkg::*;
#(
    parameter int TW             = 16,
    parameter int COOLDOWN_TICKS = 500
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Tick,
    input  logic          abort,
    input  logic          spawn,
    input  logic          shot,
    input  logic [TW-1:0] life_load,
    output logic          monster_active,
    output logic          kill_pulse,
    output logic          escape_pulse
);

    // A zero cooldown still spends exactly one cycle in COOL.
    localparam bit            ZERO_COOL = (COOLDOWN_TICKS == 0);
    localparam logic [TW-1:0] COOL_LOAD = (COOLDOWN_TICKS > 0) ? TW'(COOLDOWN_TICKS - 1) : '0;

    lane_state_t   state, state_nxt;
    logic [TW-1:0] timer, timer_nxt;
    logic          kill_nxt, escape_nxt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= LANE_IDLE;
            timer        <= '0;
            kill_pulse   <= 1'b0;
            escape_pulse <= 1'b0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            kill_pulse   <= kill_nxt;
            escape_pulse <= escape_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        kill_nxt   = 1'b0;
        escape_nxt = 1'b0;
        if (abort) begin
            state_nxt = LANE_IDLE;
        end else begin
            case (state)
                LANE_IDLE: begin
                    if (spawn) begin
                        state_nxt = LANE_ACTIVE;
                        timer_nxt = life_load;
                    end
                end
                LANE_ACTIVE: begin
                    // Shot is checked first so a shot on the expiring tick is a kill.
                    if (shot) begin
                        state_nxt = LANE_COOL;
                        timer_nxt = COOL_LOAD;
                        kill_nxt  = 1'b1;
                    end else if (Tick) begin
                        if (timer == '0) begin
                            state_nxt  = LANE_IDLE;
                            escape_nxt = 1'b1;
                        end else begin
                            timer_nxt = timer - TW'(1);
                        end
                    end
                end
                LANE_COOL: begin
                    if (ZERO_COOL) begin
                        state_nxt = LANE_IDLE;
                    end else if (Tick) begin
                        if (timer == '0) state_nxt = LANE_IDLE;
                        else             timer_nxt = timer - TW'(1);
                    end
                end
                default: state_nxt = LANE_IDLE;
            endcase
        end
    end

    assign monster_active = (state == LANE_ACTIVE);

endmodule

// File: rtl/nexys_starship_monster_ctrl.sv
// Monster controller: four independent lanes fed by PRNG spawn pulses,
// aggregated into score, lives and a latched game-over flag.
//
// Optional build macro: STARSHIP_DIFFICULTY_RAMP_EN
//   defined   -> spawn lifetime shrinks by LIFETIME_TICKS/32 per 16 kills,
//                floored at LIFETIME_TICKS/4 (assumes LIFETIME_TICKS >= 4)
//   undefined -> spawn lifetime is always LIFETIME_TICKS
//
// Ports:
//   Clk, Reset      clock, async active-high reset
//   Tick            one-Clk game-time enable
//   Play            game running; low forces all lanes idle
//   Restart         one-cycle pulse: reload lives, clear score and game_over
//   spawn_req[3:0]  {right,left,btm,top} spawn pulses
//   shot[3:0]       per-lane shot pulses
//   monster_active  per-lane live monster
//   kill_pulse      per-lane one-cycle kill pulse
//   escape_pulse    per-lane one-cycle escape pulse
//   score           kill count, saturating at 255
//   lives           remaining lives
//   game_over       set the cycle after lives reaches 0, held until Restart
module nexys_starship_monster_ctrl
    import nexys_starship_pkg::*;
#(
    parameter int TW             = 16,
    parameter int LIFETIME_TICKS = 3000,
    parameter int COOLDOWN_TICKS = 500,
    parameter int MAX_LIVES      = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Tick,
    input  logic       Play,
    input  logic       Restart,
    input  logic [3:0] spawn_req,
    input  logic [3:0] shot,
    output logic [3:0] monster_active,
    output logic [3:0] kill_pulse,
    output logic [3:0] escape_pulse,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       game_over
);

    localparam logic [1:0] LIVES_INIT = 2'(MAX_LIVES);

    logic          lane_abort;
    logic [TW-1:0] life_load;
    logic [2:0]    kill_count, escape_count;
    logic [8:0]    score_sum;
    logic [7:0]    score_nxt;
    logic [1:0]    lives_nxt;

    // Restart also clears the lanes so the new game starts empty.
    assign lane_abort = ~Play | game_over | Restart;

`ifdef STARSHIP_DIFFICULTY_RAMP_EN
    localparam logic [TW+3:0] LIFE_FULL  = (TW+4)'(LIFETIME_TICKS);
    localparam logic [TW+3:0] LIFE_STEP  = (TW+4)'(LIFETIME_TICKS / 32);
    localparam logic [TW+3:0] LIFE_FLOOR = (TW+4)'(LIFETIME_TICKS / 4);

    logic [TW+3:0] life_cut, life_ramped, life_ticks;

    always_comb begin
        life_cut    = (TW+4)'(score[7:4]) * LIFE_STEP;
        life_ramped = (life_cut >= LIFE_FULL) ? '0 : LIFE_FULL - life_cut;
        life_ticks  = (life_ramped < LIFE_FLOOR) ? LIFE_FLOOR : life_ramped;
        life_load   = TW'(life_ticks - (TW+4)'(1));
    end
`else
    assign life_load = TW'(LIFETIME_TICKS - 1);
`endif

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        nexys_starship_lane #(
            .TW             (TW),
            .COOLDOWN_TICKS (COOLDOWN_TICKS)
        ) u_lane (
            .Clk            (Clk),
            .Reset          (Reset),
            .Tick           (Tick),
            .abort          (lane_abort),
            .spawn          (spawn_req[i]),
            .shot           (shot[i]),
            .life_load      (life_load),
            .monster_active (monster_active[i]),
            .kill_pulse     (kill_pulse[i]),
            .escape_pulse   (escape_pulse[i])
        );
    end

    always_comb begin
        kill_count   = popcount4(kill_pulse);
        escape_count = popcount4(escape_pulse);
        score_sum    = {1'b0, score} + {6'b0, kill_count};
        score_nxt    = score_sum[8] ? 8'hFF : score_sum[7:0];
        lives_nxt    = ({1'b0, lives} > escape_count) ? 2'({1'b0, lives} - escape_count) : 2'd0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            score     <= '0;
            lives     <= LIVES_INIT;
            game_over <= 1'b0;
        end else if (Restart) begin
            score     <= '0;
            lives     <= LIVES_INIT;
            game_over <= 1'b0;
        end else begin
            score     <= score_nxt;
            lives     <= lives_nxt;
            game_over <= game_over | (lives == 2'd0);
        end
    end

endmodule

// File: tb/tb_nexys_starship_monster_ctrl.sv
module tb_nexys_starship_monster_ctrl;

    localparam int LIFE  = 4;
    localparam int COOL  = 2;
    localparam int MAXL  = 3;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Tick = 1'b0, Play = 1'b0, Restart = 1'b0;
    logic [3:0] spawn_req = '0, shot = '0;
    logic [3:0] monster_active, kill_pulse, escape_pulse;
    logic [7:0] score;
    logic [1:0] lives;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    nexys_starship_monster_ctrl #(
        .TW(16), .LIFETIME_TICKS(LIFE), .COOLDOWN_TICKS(COOL), .MAX_LIVES(MAXL)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Tick(Tick), .Play(Play), .Restart(Restart),
        .spawn_req(spawn_req), .shot(shot),
        .monster_active(monster_active), .kill_pulse(kill_pulse), .escape_pulse(escape_pulse),
        .score(score), .lives(lives), .game_over(game_over)
    );

    // Behavioural model: each lane tracks whether a monster is alive or cooling
    // and how many Ticks remain before that phase ends.
    bit         m_alive[4];
    bit         m_cooling[4];
    int         m_left[4];
    logic [3:0] m_kill, m_esc;
    int         m_score, m_lives;
    bit         m_go;

    task model_reset();
        for (int i = 0; i < 4; i++) begin
            m_alive[i] = 0; m_cooling[i] = 0; m_left[i] = 0;
        end
        m_kill = '0; m_esc = '0; m_score = 0; m_lives = MAXL; m_go = 0;
    endtask

    task model_step(input logic [3:0] sp, input logic [3:0] sh, input logic tk, input logic pl, input logic rs);
        int ns, nl, nk_cnt, ne_cnt;
        bit ngo, stop;
        logic [3:0] nk, ne;
        nk_cnt = $countones(m_kill);
        ne_cnt = $countones(m_esc);
        ns  = rs ? 0 : ((m_score + nk_cnt > 255) ? 255 : m_score + nk_cnt);
        nl  = rs ? MAXL : ((m_lives > ne_cnt) ? m_lives - ne_cnt : 0);
        ngo = rs ? 0 : (m_go || m_lives == 0);
        stop = rs || !pl || m_go;
        nk = '0; ne = '0;
        for (int i = 0; i < 4; i++) begin
            if (stop) begin
                m_alive[i] = 0; m_cooling[i] = 0;
            end else if (m_alive[i]) begin
                if (sh[i]) begin
                    m_alive[i] = 0; m_cooling[i] = 1; m_left[i] = COOL; nk[i] = 1'b1;
                end else if (tk) begin
                    m_left[i] = m_left[i] - 1;
                    if (m_left[i] == 0) begin
                        m_alive[i] = 0; ne[i] = 1'b1;
                    end
                end
            end else if (m_cooling[i]) begin
                if (tk) begin
                    m_left[i] = m_left[i] - 1;
                    if (m_left[i] <= 0) m_cooling[i] = 0;
                end
            end else if (sp[i]) begin
                m_alive[i] = 1; m_left[i] = LIFE;
            end
        end
        m_kill = nk; m_esc = ne; m_score = ns; m_lives = nl; m_go = ngo;
    endtask

    function automatic logic [3:0] model_active();
        logic [3:0] a;
        for (int i = 0; i < 4; i++) a[i] = m_alive[i];
        return a;
    endfunction

    task automatic cycle(input logic [3:0] sp, input logic [3:0] sh, input logic tk, input logic pl, input logic rs);
        spawn_req = sp; shot = sh; Tick = tk; Play = pl; Restart = rs;
        model_step(sp, sh, tk, pl, rs);
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge Clk);
        #1;
        checks++; if (monster_active !== 4'b0) begin errors++; $display("FAIL reset_active: got %b expected 0000", monster_active); end
        checks++; if (kill_pulse !== 4'b0) begin errors++; $display("FAIL reset_kill: got %b expected 0000", kill_pulse); end
        checks++; if (escape_pulse !== 4'b0) begin errors++; $display("FAIL reset_escape: got %b expected 0000", escape_pulse); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score: got %0d expected 0", score); end
        checks++; if (lives !== 2'(MAXL)) begin errors++; $display("FAIL reset_lives: got %0d expected %0d", lives, MAXL); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %b expected 0", game_over); end
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic test_escape();
        cycle(4'b0000, 4'b0000, 1, 1, 1);
        cycle(4'b0001, 4'b0000, 1, 1, 0);
        checks++; if (monster_active !== 4'b0001) begin errors++; $display("FAIL esc_spawn: got %b expected 0001", monster_active); end
        for (int k = 0; k < LIFE - 1; k++) begin
            cycle(4'b0000, 4'b0000, 1, 1, 0);
            checks++; if (monster_active !== 4'b0001) begin errors++; $display("FAIL esc_alive%0d: got %b expected 0001", k, monster_active); end
        end
        cycle(4'b0000, 4'b0000, 1, 1, 0);
        checks++; if (monster_active !== 4'b0000) begin errors++; $display("FAIL esc_gone: got %b expected 0000", monster_active); end
        checks++; if (escape_pulse !== 4'b0001) begin errors++; $display("FAIL esc_pulse: got %b expected 0001", escape_pulse); end
        cycle(4'b0000, 4'b0000, 1, 1, 0);
        checks++; if (lives !== 2'd2) begin errors++; $display("FAIL esc_lives: got %0d expected 2", lives); end
        checks++; if (escape_pulse !== 4'b0000) begin errors++; $display("FAIL esc_pulse_end: got %b expected 0000", escape_pulse); end
    endtask

    task automatic test_kill();
        cycle(4'b0000, 4'b0000, 1, 1, 1);
        cycle(4'b0100, 4'b0000, 1, 1, 0);
        cycle(4'b0000, 4'b0000, 1, 1, 0);
        cycle(4'b0000, 4'b0100, 1, 1, 0);
        checks++; if (kill_pulse !== 4'b0100) begin errors++; $display("FAIL kill_pulse: got %b expected 0100", kill_pulse); end
        checks++; if (monster_active !== 4'b0000) begin errors++; $display("FAIL kill_active: got %b expected 0000", monster_active); end
        cycle(4'b0100, 4'b0000, 1, 1, 0);
        checks++; if (score !== 8'd1) begin errors++; $display("FAIL kill_score: got %0d expected 1", score); end
        checks++; if (monster_active !== 4'b0000) begin errors++; $display("FAIL kill_cool_spawn1: got %b expected 0000", monster_active); end
        cycle(4'b0100, 4'b0000, 1, 1, 0);
        checks++; if (monster_active !== 4'b0000) begin errors++; $display("FAIL kill_cool_spawn2: got %b expected 0000", monster_active); end
        cycle(4'b0100, 4'b0000, 1, 1, 0);
        checks++; if (monster_active !== 4'b0100) begin errors++; $display("FAIL kill_respawn: got %b expected 0100", monster_active); end
    endtask

    task automatic test_score_saturation();
        logic [3:0] pat;
        cycle(4'b0000, 4'b0000, 1, 1, 1);
        for (int r = 0; r < 66; r++) begin
            pat = (r == 63 || r == 64) ? 4'b0011 : 4'b1111;
            cycle(pat, 4'b0000, 1, 1, 0);
            cycle(4'b0000, pat, 1, 1, 0);
            if (r == 0) begin
                checks++; if (kill_pulse !== 4'b1111) begin errors++; $display("FAIL all_kill_pulse: got %b expected 1111", kill_pulse); end
            end
            cycle(4'b0000, 4'b0000, 1, 1, 0);
            cycle(4'b0000, 4'b0000, 1, 1, 0);
            if (r == 0) begin
                checks++; if (score !== 8'd4) begin errors++; $display("FAIL all_kill_score: got %0d expected 4", score); end
            end
            if (r == 63) begin
                checks++; if (score !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d expected 254", score); end
            end
            if (r >= 64) begin
                checks++; if (score !== 8'd255) begin errors++; $display("FAIL sat_255_r%0d: got %0d expected 255", r, score); end
            end
        end
    endtask

    task automatic test_game_over();
        cycle(4'b0000, 4'b0000, 1, 1, 1);
        cycle(4'b0011, 4'b0000, 1, 1, 0);
        repeat (LIFE) cycle(4'b0000, 4'b0000, 1, 1, 0);
        cycle(4'b0000, 4'b0000, 1, 1, 0);
        checks++; if (lives !== 2'd1) begin errors++; $display("FAIL go_lives1: got %0d expected 1", lives); end
        cycle(4'b1100, 4'b0000, 1, 1, 0);
        repeat (LIFE - 1) cycle(4'b0000, 4'b0000, 1, 1, 0);
        cycle(4'b0000, 4'b0000, 1, 1, 0);
        checks++; if (escape_pulse !== 4'b1100) begin errors++; $display("FAIL go_double_escape: got %b expected 1100", escape_pulse); end
        cycle(4'b0000, 4'b0000, 1, 1, 0);
        checks++; if (lives !== 2'd0) begin errors++; $display("FAIL go_lives0: got %0d expected 0", lives); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL go_not_yet: got %b expected 0", game_over); end
        cycle(4'b0000, 4'b0000, 1, 1, 0);
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL go_set: got %b expected 1", game_over); end
        for (int k = 0; k < 3; k++) begin
            cycle(4'b1111, 4'b0000, 1, 1, 0);
            checks++; if (monster_active !== 4'b0000) begin errors++; $display("FAIL go_no_spawn%0d: got %b expected 0000", k, monster_active); end
        end
        checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL go_held: got %b expected 1", game_over); end
        cycle(4'b0000, 4'b0000, 1, 1, 1);
        checks++; if (lives !== 2'd3) begin errors++; $display("FAIL restart_lives: got %0d expected 3", lives); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL restart_score: got %0d expected 0", score); end
        checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL restart_go: got %b expected 0", game_over); end
    endtask

    task automatic test_shot_at_expiry();
        cycle(4'b0000, 4'b0000, 1, 1, 1);
        cycle(4'b0010, 4'b0000, 1, 1, 0);
        repeat (LIFE - 1) cycle(4'b0000, 4'b0000, 1, 1, 0);
        cycle(4'b0000, 4'b0010, 1, 1, 0);
        checks++; if (kill_pulse !== 4'b0010) begin errors++; $display("FAIL expiry_kill: got %b expected 0010", kill_pulse); end
        checks++; if (escape_pulse !== 4'b0000) begin errors++; $display("FAIL expiry_escape: got %b expected 0000", escape_pulse); end
        cycle(4'b0000, 4'b0000, 1, 1, 0);
        checks++; if (lives !== 2'd3) begin errors++; $display("FAIL expiry_lives: got %0d expected 3", lives); end
        checks++; if (score !== 8'd1) begin errors++; $display("FAIL expiry_score: got %0d expected 1", score); end
        checks++; if (escape_pulse !== 4'b0000) begin errors++; $display("FAIL expiry_escape_late: got %b expected 0000", escape_pulse); end
    endtask

    task automatic test_async_reset_and_play();
        cycle(4'b0001, 4'b0000, 1, 1, 0);
        cycle(4'b0000, 4'b0000, 1, 1, 0);
        checks++; if (monster_active !== 4'b0001) begin errors++; $display("FAIL ar_pre_active: got %b expected 0001", monster_active); end
        spawn_req = '0; shot = '0; Tick = 1'b0; Restart = 1'b0;
        #3 Reset = 1'b1;
        #1;
        checks++; if (monster_active !== 4'b0000) begin errors++; $display("FAIL ar_active: got %b expected 0000", monster_active); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL ar_score: got %0d expected 0", score); end
        checks++; if (lives !== 2'd3) begin errors++; $display("FAIL ar_lives: got %0d expected 3", lives); end
        model_reset();
        #2 Reset = 1'b0;
        cycle(4'b0000, 4'b0000, 1, 1, 0);
        cycle(4'b1000, 4'b0000, 1, 1, 0);
        cycle(4'b0000, 4'b0000, 1, 1, 0);
        checks++; if (monster_active !== 4'b1000) begin errors++; $display("FAIL play_pre: got %b expected 1000", monster_active); end
        cycle(4'b0000, 4'b0000, 1, 0, 0);
        checks++; if (monster_active !== 4'b0000) begin errors++; $display("FAIL play_off_active: got %b expected 0000", monster_active); end
        for (int k = 0; k < LIFE + 2; k++) begin
            cycle(4'b0000, 4'b0000, 1, 1, 0);
            checks++; if ((escape_pulse | kill_pulse) !== 4'b0000) begin errors++; $display("FAIL play_off_pulse%0d: got esc %b kill %b expected none", k, escape_pulse, kill_pulse); end
        end
        checks++; if (lives !== 2'd3) begin errors++; $display("FAIL play_off_lives: got %0d expected 3", lives); end
    endtask

    task automatic test_random();
        logic [3:0] sp, sh;
        logic tk, pl, rs;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                sp[i] = ($urandom_range(0, 5) == 0);
                sh[i] = ($urandom_range(0, 4) == 0);
            end
            tk = ($urandom_range(0, 1) == 1);
            pl = ($urandom_range(0, 39) != 0);
            rs = ($urandom_range(0, 149) == 0);
            cycle(sp, sh, tk, pl, rs);
            checks++; if (monster_active !== model_active()) begin errors++; $display("FAIL rnd_active@%0d: got %b expected %b", n, monster_active, model_active()); end
            checks++; if (kill_pulse !== m_kill) begin errors++; $display("FAIL rnd_kill@%0d: got %b expected %b", n, kill_pulse, m_kill); end
            checks++; if (escape_pulse !== m_esc) begin errors++; $display("FAIL rnd_escape@%0d: got %b expected %b", n, escape_pulse, m_esc); end
            checks++; if (score !== 8'(m_score)) begin errors++; $display("FAIL rnd_score@%0d: got %0d expected %0d", n, score, m_score); end
            checks++; if (lives !== 2'(m_lives)) begin errors++; $display("FAIL rnd_lives@%0d: got %0d expected %0d", n, lives, m_lives); end
            checks++; if (game_over !== m_go) begin errors++; $display("FAIL rnd_go@%0d: got %b expected %b", n, game_over, m_go); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_escape();
        test_kill();
        test_score_saturation();
        test_game_over();
        test_shot_at_expiry();
        test_async_reset_and_play();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nexys_starship_monster_ctrl.md
Name: nexys_starship_monster_ctrl

Overview:
- Downstream consumer of the PRNG spawn pulses (top/btm/left/right).
- Runs four independent monster lanes: spawn, lifetime countdown, shot kill, post-kill cooldown.
- Aggregates the lanes into score, lives and a latched game-over flag for the VGA/display logic.

Parameters:
- TW, 16, width of the lifetime/cooldown counters.
- LIFETIME_TICKS, 3000, number of Tick pulses a monster survives before escaping.
- COOLDOWN_TICKS, 500, number of Tick pulses after a kill before the lane may respawn.
- MAX_LIVES, 3, lives loaded at reset and on Restart.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  async active-high reset.
- Tick  in  1  one-Clk game-time enable, nominally 1 ms.
- Play  in  1  game running; low forces all lanes idle.
- Restart  in  1  one-cycle pulse: reload lives, clear score and game_over.
- spawn_req  in  4  {right,left,btm,top} PRNG pulses; bit0 is top.
- shot  in  4  per-lane shot pulses from the player FSM.
- monster_active  out  4  lane holds a live monster.
- kill_pulse  out  4  one-cycle pulse per lane on a kill.
- escape_pulse  out  4  one-cycle pulse per lane on an escape.
- score  out  8  kill count, saturating at 255.
- lives  out  2  remaining lives.
- game_over  out  1  latched once lives reaches 0.

Behaviour:
- Reset is asynchronous, active-high; clock is Clk.
- Reset values: all lanes IDLE; monster_active=0, kill_pulse=0, escape_pulse=0, score=0, lives=MAX_LIVES, game_over=0.
- Lane FSM states: IDLE, ACTIVE, COOL.
- IDLE -> ACTIVE when spawn_req[i] & Play & ~game_over. Timer loads LIFETIME_TICKS-1. monster_active[i] rises the next cycle. Spawn is ignored in every other state; requests are not queued.
- ACTIVE:
  - shot[i] -> COOL, kill_pulse[i]=1 for one cycle, timer loads COOLDOWN_TICKS-1.
  - else Tick with timer==0 -> IDLE, escape_pulse[i]=1 for one cycle.
  - else Tick -> timer decrements.
  - A shot in the same cycle as expiry counts as a kill (shot wins).
  - shot in IDLE or COOL is ignored.
- COOL: Tick with timer==0 -> IDLE; otherwise Tick decrements. COOLDOWN_TICKS=0 means one cycle in COOL.
- Counters change only on Tick cycles, except for loads at state entry.
- Play=0 or game_over=1: all lanes go to IDLE on the next edge with no pulses. Score and lives hold.
- Score:
  - Increments by the popcount of kill_pulse, up to +4 per cycle.
  - Saturates at 255; no wrap.
- Lives:
  - Decrements by the popcount of escape_pulse, floor 0.
  - game_over sets the cycle after lives becomes 0 and stays set.
- Restart has priority over same-cycle kills and escapes: lives=MAX_LIVES, score=0, game_over=0, lanes IDLE.
- Reset mid-operation returns immediately to the reset values.
- Latency:
  - spawn_req -> monster_active: 1 cycle.
  - shot -> kill_pulse: 1 cycle.
  - kill_pulse -> score update: 1 cycle.

Optional Feature:
- Macro: STARSHIP_DIFFICULTY_RAMP_EN.
- Defined: lifetime loaded at spawn = LIFETIME_TICKS - score[7:4]*(LIFETIME_TICKS/32). This is computed at TW+4 bits with a floor of LIFETIME_TICKS/4, so monsters shorten every 16 kills.
- Undefined: lifetime is always LIFETIME_TICKS.

Decomposition:
- Package nexys_starship_pkg holds:
  - lane index constants LANE_TOP=0, LANE_BTM=1, LANE_LEFT=2, LANE_RIGHT=3;
  - the lane state encoding (IDLE=2'd0, ACTIVE=2'd1, COOL=2'd2);
  - a popcount4 function.
- Sub-module nexys_starship_lane: one FSM plus timer, instantiated four times. The top level owns score, lives, game_over and Restart.

Test Plan:
- LIFETIME=4, COOL=2, Tick every cycle. spawn_req=0001, no shot -> monster_active[0] high for 4 Ticks, then escape_pulse[0], lives 3->2.
- Spawn lane 2, shot[2] two cycles later -> kill_pulse[2], score 0->1, lane stays IDLE for 2 Ticks, and a spawn_req[2] during COOL is ignored.
- All four lanes active, shot=1111 in one cycle -> score +4. Separately, score at 254 plus two kills -> 255.
- lives=1, two lanes escape on the same cycle -> lives=0, game_over=1 next cycle; further spawn_req produces no activity. Restart -> lives=3, score=0, game_over=0.
- shot[1] coincident with the final expiring Tick -> kill_pulse[1]=1, escape_pulse[1]=0, lives unchanged.
- Lane active mid-lifetime, assert Reset asynchronously between edges -> outputs go to reset values immediately. Play=0 mid-lifetime -> lane IDLE next edge, no pulses.
